// File: rtl/mem_responder.sv
// Single-outstanding memory responder with WAIT_STATES extra cycles before each one-cycle ready.
// Define MEM_RESPONDER_MMIO_EN to add the sticky halt register and the free-running cycle counter.
module mem_responder #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] HALT_ADDR   = 32'hFFFF_FFF0,
  parameter logic [31:0] CYCLE_ADDR  = 32'hFFFF_FFF4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic [31:0] address,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        halt
);

  localparam int unsigned IDX_W      = $clog2(MEM_WORDS);
  localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);
  localparam logic [3:0]  WAIT_LOAD  = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

`ifdef MEM_RESPONDER_MMIO_EN
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [31:0] mem [MEM_WORDS];

  logic [31:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic             acc_we;
  logic             go_resp;
  logic [IDX_W-1:0] acc_idx;
  logic             in_range;
  logic             hit_halt;
  logic             hit_cycle;
  logic             mem_wr;
  logic [31:0]      cycle_val;
  logic             halt_val;

  // With zero wait states the access completes on its accepting edge, so the live inputs are used.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    acc_addr  = addr_q;
    acc_we    = we_q;
    acc_wdata = wdata_q;
    if (state == ST_IDLE) begin
      acc_addr  = address;
      acc_we    = we;
      acc_wdata = wdata;
    end
  end

  assign go_resp   = ((state == ST_IDLE) && req && (WAIT_STATES == 0)) ||
                     ((state == ST_WAIT) && (wait_cnt == 4'd0));
  assign acc_idx   = acc_addr[IDX_W+1:2];
  assign in_range  = (acc_addr[31:2] < WORD_LIMIT) && (acc_addr[1:0] == 2'b00);
  assign hit_halt  = MMIO_EN && (acc_addr == HALT_ADDR);
  assign hit_cycle = MMIO_EN && (acc_addr == CYCLE_ADDR);
  assign mem_wr    = resetn && go_resp && acc_we && in_range && !hit_halt && !hit_cycle;

  // NOTE: the backing array is deliberately left out of reset so it maps onto RAM, not flops.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      ready    <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
    end else begin
      ready <= go_resp;
      err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            addr_q  <= address;
            we_q    <= we;
            wdata_q <= wdata;
            if (WAIT_STATES == 0) begin
              state <= ST_RESP;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) state <= ST_RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      if (go_resp) begin
        if (hit_halt) begin
          rdata <= acc_we ? 32'd0 : {31'd0, halt_val};
        end else if (hit_cycle) begin
          rdata <= acc_we ? 32'd0 : cycle_val;
        end else if (in_range) begin
          rdata <= acc_we ? 32'd0 : mem[acc_idx];
        end else begin
          rdata <= 32'd0;
          err   <= 1'b1;
        end
      end
    end
  end

`ifdef MEM_RESPONDER_MMIO_EN
  logic [31:0] cycle_cnt;
  logic        halt_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cycle_cnt <= '0;
      halt_q    <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (go_resp && hit_halt && acc_we) halt_q <= 1'b1;
    end
  end

  assign cycle_val = cycle_cnt;
  assign halt_val  = halt_q;
`else
  assign cycle_val = 32'd0;
  assign halt_val  = 1'b0;
`endif

  assign halt = halt_val;

endmodule
